// File: rtl/seg7_result_display_if.sv
// Result/display bundle between the execution unit, the display stage and its observer.
// master drives value/err; slave (the display stage) drives the panel and status outputs.
interface seg7_result_display_if;
  logic [16:0] value;
  logic        err;
  logic [4:0]  an;
  logic [6:0]  seg;
  logic [19:0] bcd;
  logic        busy;

  modport master (
    output value, err,
    input  an, seg, bcd, busy
  );

  modport slave (
    input  value, err,
    output an, seg, bcd, busy
  );
endinterface

// File: rtl/seg7_result_display.sv
// Binary result -> BCD via double-dabble (bcd valid 18 cycles after a value change), scanned 5-digit 7-seg.
// No backpressure: value/err sampled every cycle; value changes during a conversion are picked up when it ends.
module seg7_result_display #(
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  seg7_result_display_if.slave  io_disp
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CONV  = 2'd1,
    S_LATCH = 2'd2
  } state_t;

  localparam int          CW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [4:0]  N_BITS    = 5'd17;
  localparam logic [16:0] MAX_DEC   = 17'd99999;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;

  // Conversion datapath: BCD nibbles live in [36:17], the binary operand in [16:0].
  state_t       r_state;
  state_t       w_state_nxt;
  logic [16:0]  r_last_value;
  logic [16:0]  w_last_value_nxt;
  logic [36:0]  r_shift;
  logic [36:0]  w_shift_nxt;
  logic [4:0]   r_cnt;
  logic [4:0]   w_cnt_nxt;
  logic [19:0]  r_bcd;
  logic [19:0]  w_bcd_nxt;
  logic         r_busy;
  logic         w_busy_nxt;

  // Scan datapath.
  logic [CW-1:0] r_scan_cnt;
  logic [2:0]    r_idx;
  logic [2:0]    w_idx_nxt;
  logic [4:0]    r_an;
  logic [6:0]    r_seg;
  logic [6:0]    w_seg_nxt;
  logic [3:0]    w_digit;
  logic          w_upper_zero;
  logic          w_ovf;

  function automatic logic [36:0] dd_step(input logic [36:0] s);
    logic [36:0] t;
    t = s;
    for (int k = 0; k < 5; k++) begin
      if (t[17 + 4*k +: 4] >= 4'd5) begin
        t[17 + 4*k +: 4] = t[17 + 4*k +: 4] + 4'd3;
      end
    end
    return {t[35:0], 1'b0};
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_last_value <= '0;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_bcd        <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_value <= w_last_value_nxt;
      r_shift      <= w_shift_nxt;
      r_cnt        <= w_cnt_nxt;
      r_bcd        <= w_bcd_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_last_value_nxt = r_last_value;
    w_shift_nxt      = r_shift;
    w_cnt_nxt        = r_cnt;
    w_bcd_nxt        = r_bcd;
    w_busy_nxt       = r_busy;
    case (r_state)
      S_IDLE: begin
        if (io_disp.value != r_last_value) begin
          w_last_value_nxt = io_disp.value;
          w_shift_nxt      = {20'b0, io_disp.value};
          w_cnt_nxt        = N_BITS;
          w_busy_nxt       = 1'b1;
          w_state_nxt      = S_CONV;
        end
      end
      S_CONV: begin
        w_shift_nxt = dd_step(r_shift);
        w_cnt_nxt   = r_cnt - 5'd1;
        if (r_cnt == 5'd1) begin
          w_state_nxt = S_LATCH;
        end
      end
      S_LATCH: begin
        w_bcd_nxt   = r_shift[36:17];
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Overflow tracks the most recently captured value, not the latched digits.
  assign w_ovf        = (r_last_value > MAX_DEC);
  assign w_idx_nxt    = (r_idx == 3'd4) ? 3'd0 : r_idx + 3'd1;
  assign w_digit      = r_bcd[{w_idx_nxt, 2'b00} +: 4];
  assign w_upper_zero = ((r_bcd >> {w_idx_nxt, 2'b00}) == 20'd0);

  always_comb begin
    w_seg_nxt = seg_decode(w_digit);
    if (BLANK_LZ && (w_idx_nxt != 3'd0) && w_upper_zero) begin
      w_seg_nxt = SEG_BLANK;
    end
    if (io_disp.err || w_ovf) begin
      case (w_idx_nxt)
        3'd2:       w_seg_nxt = SEG_E;
        3'd1, 3'd0: w_seg_nxt = SEG_R;
        default:    w_seg_nxt = SEG_BLANK;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_scan_cnt <= '0;
      r_idx      <= 3'd0;
      r_an       <= 5'b11110;
      r_seg      <= 7'b1000000;
    end else if (r_scan_cnt == CNT_MAX) begin
      r_scan_cnt <= '0;
      r_idx      <= w_idx_nxt;
      r_an       <= ~(5'b00001 << w_idx_nxt);
      r_seg      <= w_seg_nxt;
    end else begin
      r_scan_cnt <= r_scan_cnt + CW'(1);
    end
  end

  assign io_disp.an   = r_an;
  assign io_disp.seg  = r_seg;
  assign io_disp.bcd  = r_bcd;
  assign io_disp.busy = r_busy;

endmodule

// File: tb/tb_seg7_result_display.sv
// Scoreboard bench: two DUTs (leading-zero blanking on/off) fed the same random results.
module tb_seg7_result_display;

  localparam int SCAN = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [16:0] tb_value = '0;
  logic        tb_err = 1'b0;

  seg7_result_display_if bus_a ();
  seg7_result_display_if bus_b ();

  assign bus_a.value = tb_value;
  assign bus_a.err   = tb_err;
  assign bus_b.value = tb_value;
  assign bus_b.err   = tb_err;

  seg7_result_display #(.SCAN_DIV(SCAN), .BLANK_LZ(1'b1)) u_dut_a (
    .clk(clk), .reset(reset), .io_disp(bus_a)
  );
  seg7_result_display #(.SCAN_DIV(SCAN), .BLANK_LZ(1'b0)) u_dut_b (
    .clk(clk), .reset(reset), .io_disp(bus_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [34:0] a;
    logic [34:0] b;
  } frame_t;

  int     n_checks = 0;
  int     n_pass   = 0;
  int     q_bcd[$];
  frame_t q_frame[$];
  frame_t cur_frame;
  int     frm_left = 0;
  int     m_last = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    $display("FAIL %s timeout t=%0t", nm, $time);
  endtask

  // Reference: decimal digits by plain arithmetic; a 5-nibble register keeps the low five digits.
  function automatic logic [19:0] to_bcd(input int v);
    int r;
    logic [19:0] b;
    r = v % 100000;
    b = '0;
    for (int k = 0; k < 5; k++) begin
      b[4*k +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return b;
  endfunction

  function automatic logic [6:0] digit_seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  function automatic logic [34:0] exp_frame(input int v, input bit e, input bit blz);
    logic [34:0] f;
    int pw;
    pw = 1;
    for (int k = 0; k < 5; k++) begin
      if (e || v > 99999)
        f[7*k +: 7] = (k == 2) ? 7'b0000110 : (k < 2) ? 7'b0101111 : 7'b1111111;
      else if (blz && k > 0 && v < pw)
        f[7*k +: 7] = 7'b1111111;
      else
        f[7*k +: 7] = digit_seg((v / pw) % 10);
      pw = pw * 10;
    end
    return f;
  endfunction

  // Conversion monitor: each busy pulse must last 18 cycles and end with the next expected digits.
  int mon_busy_cycles = 0;
  bit mon_prev_busy = 1'b0;
  int mon_v;
  always @(negedge clk) begin
    if (reset) begin
      mon_busy_cycles = 0;
      mon_prev_busy   = 1'b0;
    end else begin
      if (bus_a.busy === 1'b1) begin
        mon_busy_cycles++;
      end else if (mon_prev_busy) begin
        if (q_bcd.size() == 0) begin
          fail_now("unexpected_conversion");
        end else begin
          mon_v = q_bcd.pop_front();
          chk("bcd_a", 32'(bus_a.bcd), 32'(to_bcd(mon_v)));
          chk("bcd_b", 32'(bus_b.bcd), 32'(to_bcd(mon_v)));
          chk("busy_len", 32'(mon_busy_cycles), 32'd18);
        end
        mon_busy_cycles = 0;
      end
      mon_prev_busy = (bus_a.busy === 1'b1);
    end
  end

  // Display monitor: after a frame is queued, the next five scan updates are compared.
  logic [4:0] prev_an = '1;
  always @(negedge clk) begin
    if (!reset) begin
      if (frm_left == 0) begin
        if (q_frame.size() > 0) begin
          cur_frame = q_frame.pop_front();
          frm_left  = 5;
        end
      end else if (bus_a.an !== prev_an) begin
        chk("an_onehot", 32'($countones(~bus_a.an)), 32'd1);
        chk("an_b", 32'(bus_b.an), 32'(bus_a.an));
        for (int k = 0; k < 5; k++) begin
          if (bus_a.an[k] === 1'b0) begin
            chk($sformatf("seg_a_d%0d", k), 32'(bus_a.seg), 32'(cur_frame.a[7*k +: 7]));
            chk($sformatf("seg_b_d%0d", k), 32'(bus_b.seg), 32'(cur_frame.b[7*k +: 7]));
          end
        end
        frm_left--;
      end
    end
    prev_an = bus_a.an;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_value(input int v);
    tb_value = 17'(v);
    if (v != m_last) q_bcd.push_back(v);
    m_last = v;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((q_bcd.size() != 0 || bus_a.busy !== 1'b0) && t < 400) begin
      tick(1);
      t++;
    end
    if (t >= 400) begin
      fail_now("wait_idle");
      q_bcd.delete();
    end
  endtask

  task automatic check_frame(input bit e);
    frame_t f;
    int t;
    tb_err = e;
    f.a = exp_frame(m_last, e, 1'b1);
    f.b = exp_frame(m_last, e, 1'b0);
    q_frame.push_back(f);
    t = 0;
    tick(1);
    while ((q_frame.size() != 0 || frm_left != 0) && t < 100) begin
      tick(1);
      t++;
    end
    if (t >= 100) begin
      fail_now("frame");
      q_frame.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    chk("rst_an", 32'(bus_a.an), 32'h1E);
    chk("rst_seg", 32'(bus_a.seg), 32'h40);
    chk("rst_bcd", 32'(bus_a.bcd), 32'h0);
    chk("rst_busy", 32'(bus_a.busy), 32'h0);
    reset = 1'b0;
    check_frame(1'b0);

    set_value(12345);  wait_idle(); check_frame(1'b0);
    set_value(99999);  wait_idle(); check_frame(1'b0);
    set_value(100000); wait_idle(); check_frame(1'b0);
    set_value(507);    wait_idle(); check_frame(1'b0);

    // Change arrives mid-conversion: both values must be converted in order.
    set_value(42);
    tick(5);
    set_value(77);
    wait_idle(); check_frame(1'b0);

    set_value(250); wait_idle();
    check_frame(1'b1);
    check_frame(1'b0);

    // Reset during CONV aborts; the still-different input reconverts afterwards.
    set_value(12345);
    tick(5);
    reset = 1'b1;
    tick(1);
    chk("abort_bcd", 32'(bus_a.bcd), 32'h0);
    chk("abort_busy", 32'(bus_a.busy), 32'h0);
    chk("abort_an", 32'(bus_a.an), 32'h1E);
    reset = 1'b0;
    wait_idle(); check_frame(1'b0);

    for (int i = 0; i < 24; i++) begin
      if (i % 2 == 0) set_value(int'($urandom_range(0, 131071)));
      else            set_value(int'($urandom_range(0, 999)));
      tick(int'($urandom_range(0, 3)));
      wait_idle();
      if (i % 3 == 0) check_frame(1'($urandom_range(0, 1)));
      tb_err = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
